// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the parametrised SRAM wrapper.
package sram_pkg;

  // Wrapper control states: zero-fill sweep after reset, then serve requests.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 2;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit mask_gran_ok(input int width, input int gran);
    return (gran > 0) && (width >= gran) && ((width % gran) == 0);
  endfunction

  function automatic bit read_lat_ok(input int lat);
    return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
  endfunction

endpackage

// File: rtl/sram_array_core.sv
// Behavioural single-port storage: per-lane masked write, registered read.
// Deliberately reset-free so synthesis maps it onto block RAM.
module sram_array_core
  import sram_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int WIDTH     = 73,
  parameter int MASK_GRAN = 73,
  parameter int LANES     = WIDTH / MASK_GRAN,
  parameter int AW        = addr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [LANES-1:0] i_wmask,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Masked lane write on write strobes; read port only updates on reads.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < LANES; i++) begin
          if (i_wmask[i]) begin
            r_mem[i_addr][i*MASK_GRAN +: MASK_GRAN] <= i_wdata[i*MASK_GRAN +: MASK_GRAN];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_array_ext_gen.sv
// Parametrised single-port RAM wrapper: zero-fill after reset, request
// ready/valid handshake, read latency of 1 or 2 cycles.
module sram_array_ext_gen
  import sram_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int WIDTH        = 73,
  parameter int MASK_GRAN    = 73,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                         RW0_clk,
  input  logic                         reset,
  input  logic [addr_w(DEPTH)-1:0]     RW0_addr,
  input  logic                         RW0_en,
  input  logic                         RW0_wmode,
  input  logic [WIDTH/MASK_GRAN-1:0]   RW0_wmask,
  input  logic [WIDTH-1:0]             RW0_wdata,
  output logic                         RW0_ready,
  output logic [WIDTH-1:0]             RW0_rdata,
  output logic                         RW0_rvalid
);

  localparam int     AW        = addr_w(DEPTH);
  localparam int     LANES     = WIDTH / MASK_GRAN;
  localparam state_t RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sram_array_ext_gen: DEPTH must be a power of two >= 2");
  end
  if (!mask_gran_ok(WIDTH, MASK_GRAN)) begin : g_bad_gran
    $error("sram_array_ext_gen: WIDTH must be a multiple of MASK_GRAN");
  end
  if (!read_lat_ok(READ_LATENCY)) begin : g_bad_lat
    $error("sram_array_ext_gen: READ_LATENCY must be 1 or 2");
  end

  state_t                 r_state;
  logic [AW-1:0]          r_cnt;
  logic                   r_ready;
  logic [READ_LATENCY:1]  r_vld_pipe;

  logic                   w_init;
  logic                   w_acc;
  logic                   w_rd;
  logic                   w_core_en;
  logic                   w_core_we;
  logic [AW-1:0]          w_core_addr;
  logic [LANES-1:0]       w_core_wmask;
  logic [WIDTH-1:0]       w_core_wdata;
  logic [WIDTH-1:0]       w_core_rdata;

  // Init sweep walks every address once, then hands the port to the user.
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        ST_IDLE: r_ready <= 1'b1;
        default: r_state <= RST_STATE;
      endcase
    end
  end

  assign w_init = (r_state == ST_INIT);
  // Ready is only high in IDLE, so user requests can never collide with the sweep.
  assign w_acc  = RW0_en & r_ready;
  assign w_rd   = w_acc & ~RW0_wmode;

  // Port mux: the init sweep owns the array until it finishes.
  always_comb begin
    w_core_en    = w_acc;
    w_core_we    = RW0_wmode;
    w_core_addr  = RW0_addr;
    w_core_wmask = RW0_wmask;
    w_core_wdata = RW0_wdata;
    if (w_init) begin
      w_core_en    = 1'b1;
      w_core_we    = 1'b1;
      w_core_addr  = r_cnt;
      w_core_wmask = '1;
      w_core_wdata = '0;
    end
  end

  sram_array_core #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN),
    .LANES     (LANES),
    .AW        (AW)
  ) u_core (
    .i_clk   (RW0_clk),
    .i_en    (w_core_en),
    .i_we    (w_core_we),
    .i_addr  (w_core_addr),
    .i_wmask (w_core_wmask),
    .i_wdata (w_core_wdata),
    .o_rdata (w_core_rdata)
  );

  // Read-valid shift register; stage 1 lines up with the array read register.
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_rd;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
      end
    end
  end

  assign RW0_rvalid = r_vld_pipe[READ_LATENCY];
  assign RW0_ready  = r_ready;

  if (READ_LATENCY == 2) begin : g_oreg
    logic [WIDTH-1:0] r_rdata;

    // Output register captures array data only when a read lands, so it holds otherwise.
    always_ff @(posedge RW0_clk or posedge reset) begin
      if (reset) begin
        r_rdata <= '0;
      end else if (r_vld_pipe[1]) begin
        r_rdata <= w_core_rdata;
      end
    end

    assign RW0_rdata = r_rdata;
  end else begin : g_direct
    logic r_rd_seen;

    // The array register has no reset; mask it to zero until a read lands after reset.
    always_ff @(posedge RW0_clk or posedge reset) begin
      if (reset) begin
        r_rd_seen <= 1'b0;
      end else if (w_rd) begin
        r_rd_seen <= 1'b1;
      end
    end

    assign RW0_rdata = r_rd_seen ? w_core_rdata : '0;
  end

endmodule

// File: doc/sram_array_ext_gen.md
Name: sram_array_ext_gen

Overview:
- Parametrised single-port synchronous RAM wrapper. Successor to the fixed 512x73 cache-array wrappers.
- Adds generic depth and width, a per-lane write mask, and a configurable read latency (1 or 2).
- Adds hardware zero-initialisation after reset, with a ready/valid handshake on the request and read-data sides.
- Instantiated by cache tag/data arrays in place of per-size vendor BRAM wrappers.

Parameters:
- DEPTH, 512, number of words; must be a power of two, >= 2.
- WIDTH, 73, data bits per word.
- MASK_GRAN, 73, bits per write-mask lane; WIDTH must be a multiple of MASK_GRAN.
- READ_LATENCY, 1, cycles from accepted read to RW0_rvalid; legal values 1 or 2.
- INIT_ZERO, 1, 1 = clear every word after reset; 0 = skip init.

Ports:
- RW0_clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- RW0_addr  input  $clog2(DEPTH)  word address.
- RW0_en  input  1  request strobe.
- RW0_wmode  input  1  1 = write, 0 = read.
- RW0_wmask  input  WIDTH/MASK_GRAN  per-lane write enable; ignored on reads.
- RW0_wdata  input  WIDTH  write data.
- RW0_ready  output  1  request accepted this cycle when RW0_en && RW0_ready.
- RW0_rdata  output  WIDTH  read data; holds its value between reads.
- RW0_rvalid  output  1  one-cycle pulse marking new RW0_rdata.

Behaviour:
- Reset values: RW0_ready=0, RW0_rvalid=0, RW0_rdata=0, init counter=0, all pipeline valids=0.
  - Memory contents are not reset asynchronously; they are cleared by the INIT state.
- FSM states:
  - INIT: entered from reset when INIT_ZERO=1. Writes all-zero to address cnt each cycle, then cnt++.
    - After the write to DEPTH-1 (wrap point), go to IDLE.
    - RW0_ready=0 throughout.
    - Duration is exactly DEPTH cycles after reset deassertion.
  - IDLE: RW0_ready=1. Entered directly from reset when INIT_ZERO=0.
- Reset asserted mid-INIT or mid-read: FSM returns to INIT, cnt=0, and any in-flight rvalid is dropped. Init restarts from address 0.
- Requests with RW0_en=1 while RW0_ready=0 are ignored: no write, no rvalid, no queuing.
- Write (en && ready && wmode):
  - Lane i of mem[addr] takes wdata[i*MASK_GRAN +: MASK_GRAN] iff wmask[i]; other lanes are unchanged.
  - wmask all-zero is a legal no-op.
  - RW0_rdata and RW0_rvalid are unaffected.
- Read (en && ready && !wmode):
  - READ_LATENCY=1: RW0_rdata=mem[addr] and RW0_rvalid=1 on the next edge.
  - READ_LATENCY=2: an extra output register stage; rdata and rvalid appear one cycle later.
  - Back-to-back reads every cycle are fully pipelined, throughput 1 per cycle.
- Ordering: a read issued the cycle after a write to the same address returns the new data. No bypass is needed, since the operations are sequential on a single port.
- Output hold: RW0_rdata keeps its last value until the next rvalid. It is never updated by writes or idle cycles.
- Address is always in range by construction (DEPTH is a power of two), so no bounds checking is needed.
- Simultaneous reset and request: reset wins.
- Width rule: the mask lane count is exactly WIDTH/MASK_GRAN. Elaboration fails (static assertion) if the division is not exact or READ_LATENCY is not in {1,2}.

Decomposition:
- Shared package sram_pkg:
  - state enum {ST_INIT, ST_IDLE}
  - function addr_w(depth) = $clog2(depth)
  - localparam checks for MASK_GRAN divisibility and READ_LATENCY range.
- Sub-module sram_array_core:
  - Behavioural storage array with a per-lane masked write loop and a registered read.
  - Has no reset, so it infers block RAM.
- The wrapper holds the FSM, init counter, port muxing (init vs. user), valid pipeline and optional output register.

Test Plan:
- Init: DEPTH=512, INIT_ZERO=1. Release reset -> RW0_ready=0 for exactly 512 cycles, then 1. A read of addr 0x1FF returns 0, with rvalid one cycle later.
- Masked write: WIDTH=64, MASK_GRAN=8.
  - Write 0x1122334455667788 to addr 5 with mask 0xFF, then write 0xAAAAAAAAAAAAAAAA with mask 0x0F.
  - Read addr 5 -> 0x11223344AAAAAAAA.
- Latency and pipelining: READ_LATENCY=2. Reads of addr 1,2,3 on consecutive cycles -> rvalid high for 3 consecutive cycles, starting 2 cycles after the first read, data in order.
- Hold and write-after-read: read addr 7 (=0x5A), then idle 4 cycles, then write addr 7 -> RW0_rdata stays 0x5A with rvalid=0 throughout.
- Ignored request: assert RW0_en with a write to addr 3 during INIT (cycle 10) -> addr 3 reads 0 after init completes.
- Reset mid-operation:
  - Assert reset at init cycle 200 -> ready=0, restarts from 0, ready rises 512 cycles after release.
  - A read in flight when reset is asserted yields no rvalid.
